// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the serial ADC reader.
package adc_spi_pkg;

    // Default frame geometry: 4 leading zeros followed by 12 data bits.
    localparam int FRAME_BITS_DEF = 16;
    localparam int DATA_BITS_DEF  = 12;
    localparam int LEAD_BITS      = FRAME_BITS_DEF - DATA_BITS_DEF;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Shortest sample period that still fits one frame plus the quiet gap.
    function automatic int min_sample_period(input int clk_div, input int frame_bits,
                                             input int quiet_cycles);
        return (2 * frame_bits + 1) * clk_div + 1 + quiet_cycles;
    endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// Free-running sample-rate counter; emits a start tick at count 0 while enabled.
module adc_sample_timer #(
    parameter int PERIOD = 6250
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic start_tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    // Wrap counter, held at zero while disabled so the first tick follows enable at once.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            count <= '0;
        end else if (count == CW'(PERIOD - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign start_tick = enable && (count == '0);

endmodule

// File: rtl/adc_spi_reader.sv
// Reads a serial ADC frame per sample period and presents the payload as a strobe.
//
// Handshake: adc_data_valid is a one-cycle strobe with no back-pressure; adc_data
// is valid on that cycle and stays held until the next completed frame.
module adc_spi_reader #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 6250,
    parameter int QUIET_CYCLES  = 4,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 adc_sdo,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] adc_data,
    output logic                 adc_data_valid,
    output logic                 frame_error
);

    import adc_spi_pkg::*;

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);

    if (SAMPLE_PERIOD < min_sample_period(CLK_DIV, FRAME_BITS, QUIET_CYCLES)) begin : g_period_check
        $error("adc_spi_reader: SAMPLE_PERIOD too short for one frame plus quiet time");
    end

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   hcnt;
    logic            phase;      // 0 = sclk low half, 1 = sclk high half
    logic [BW-1:0]   bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic            start_tick;
    logic            half_done;
    logic            last_bit;
    logic            cs_n_next;
    logic            sclk_next;
    logic            sclk_rise;

    adc_sample_timer #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start_tick (start_tick)
    );

    assign half_done = (hcnt == HW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BW'(FRAME_BITS - 1));
    // Capture on the edge where the registered sclk goes from low to high.
    assign sclk_rise = (state == SHIFT) && sclk_next && !adc_sclk;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-pin-level decode; pins are registered one cycle later.
    always_comb begin
        state_next = state;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b1;
        case (state)
            IDLE: begin
                if (start_tick) state_next = SETUP;
            end
            SETUP: begin
                cs_n_next = 1'b0;
                if (half_done) state_next = SHIFT;
            end
            SHIFT: begin
                cs_n_next = 1'b0;
                sclk_next = phase;
                if (half_done && phase && last_bit) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Half-period timing, bit counting and serial capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt    <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                SETUP: begin
                    hcnt <= half_done ? '0 : hcnt + 1'b1;
                end
                SHIFT: begin
                    if (half_done) begin
                        hcnt  <= '0;
                        phase <= ~phase;
                        if (phase) bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                    if (sclk_rise) shift <= {shift[FRAME_BITS-2:0], adc_sdo};
                end
                default: begin
                    hcnt    <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Registered pins and the result strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_cs_n       <= 1'b1;
            adc_sclk       <= 1'b1;
            adc_data       <= '0;
            adc_data_valid <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            adc_cs_n       <= cs_n_next;
            adc_sclk       <= sclk_next;
            adc_data_valid <= (state == DONE);
            frame_error    <= (state == DONE) && (|shift[FRAME_BITS-1:DATA_BITS]);
            if (state == DONE) adc_data <= shift[DATA_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed and randomized checks of adc_spi_reader against a frame-level ADC model.
module tb_adc_spi_reader;

    localparam int CD  = 2;
    localparam int SP  = 100;
    localparam int QC  = 4;
    localparam int FB  = 16;
    localparam int DB  = 12;
    localparam int LAT = (2 * FB + 1) * CD + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic adc_sdo = 1'b0;
    logic adc_cs_n;
    logic adc_sclk;
    logic [DB-1:0] adc_data;
    logic adc_data_valid;
    logic frame_error;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_reader #(
        .CLK_DIV       (CD),
        .SAMPLE_PERIOD (SP),
        .QUIET_CYCLES  (QC),
        .FRAME_BITS    (FB),
        .DATA_BITS     (DB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .adc_sdo        (adc_sdo),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .frame_error    (frame_error)
    );

    // ---------------- ADC model: next word bit on each sclk fall ----------------
    logic [FB-1:0] adc_word = '0;
    int bit_idx = FB - 1;
    always @(negedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n === 1'b1) begin
            bit_idx = FB - 1;
        end else if (bit_idx >= 0) begin
            adc_sdo = adc_word[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    // ---------------- bus monitors ----------------
    int rise_cnt = 0;
    int cs_fall_cnt = 0;
    int sclk_fall_cnt = 0;
    int hi_run = 0;
    int min_hi = 1000000;
    always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rise_cnt++;
    always @(negedge adc_cs_n) cs_fall_cnt++;
    always @(negedge adc_sclk) sclk_fall_cnt++;
    always @(negedge clk) begin
        if (adc_cs_n === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
            hi_run = 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [DB:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Expected result for one ADC word: {leading bits nonzero, payload}.
    function automatic logic [DB:0] ref_result(input logic [FB-1:0] word);
        logic [FB-1:0] lead;
        lead = word >> DB;
        return {(lead != '0), word[DB-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [FB-1:0] w);
        adc_word = w;
        exp_q.push_back(ref_result(w));
    endtask

    // Follow one frame whose start tick lands on edge s; optionally drop enable
    // so that it is sampled low at edge s+drop_at.
    task automatic run_frame(input string tag, input int s, input int drop_at);
        int t;
        logic [DB:0] exp;
        rise_cnt = 0;
        t = -1;
        for (int i = 0; i < SP + 10; i++) begin
            @(negedge clk);
            if (adc_cs_n === 1'b0) begin
                t = cyc;
                break;
            end
        end
        chk({tag, "_cs_fall"}, t, s + 1);
        t = -1;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (drop_at > 0 && cyc == s + drop_at - 1) enable = 1'b0;
            if (adc_data_valid === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk({tag, "_valid_cycle"}, t, s + LAT);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_data"}, 32'(adc_data), 32'(exp[DB-1:0]));
        chk({tag, "_frame_error"}, 32'(frame_error), 32'(exp[DB]));
        chk({tag, "_sclk_rises"}, rise_cnt, FB);
        @(negedge clk);
        chk({tag, "_valid_width"}, 32'(adc_data_valid), 0);
        chk({tag, "_error_width"}, 32'(frame_error), 0);
        chk({tag, "_data_held"}, 32'(adc_data), 32'(exp[DB-1:0]));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        int bad_cs;
        int bad_sclk;
        int bad_valid;
        int falls0;
        int sfalls0;
        logic [FB-1:0] w;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 1);
        chk("rst_sclk", 32'(adc_sclk), 1);
        chk("rst_data", 32'(adc_data), 0);
        chk("rst_valid", 32'(adc_data_valid), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        reset = 1'b1;

        // Idle with enable low: bus stays quiet.
        bad_cs = 0; bad_sclk = 0; bad_valid = 0;
        falls0 = cs_fall_cnt;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (adc_cs_n !== 1'b1) bad_cs++;
            if (adc_sclk !== 1'b1) bad_sclk++;
            if (adc_data_valid !== 1'b0) bad_valid++;
        end
        chk("idle_cs_n", bad_cs, 0);
        chk("idle_sclk", bad_sclk, 0);
        chk("idle_valid", bad_valid, 0);
        chk("idle_cs_falls", cs_fall_cnt - falls0, 0);

        // Single frame straight after enable rises.
        push_word(16'h0ABC);
        enable = 1'b1;
        s = cyc + 1;
        run_frame("single", s, 0);

        // Continuous sampling at the fixed period.
        min_hi = 1000000;
        push_word(16'h0000); s = s + SP; run_frame("cont0", s, 0);
        push_word(16'h0FFF); s = s + SP; run_frame("cont1", s, 0);
        push_word(16'h0555); s = s + SP; run_frame("cont2", s, 0);
        chk("quiet_gap_ok", 32'(min_hi >= QC), 1);

        // Leading-bit fault.
        push_word(16'h8123); s = s + SP; run_frame("lead_fault", s, 0);

        // Random words, with and without leading-bit faults.
        for (int k = 0; k < 4; k++) begin
            w = FB'($urandom_range(0, 16'hFFFF));
            if (k[0]) w[FB-1 -: (FB - DB)] = '0;
            push_word(w); s = s + SP; run_frame($sformatf("rand%0d", k), s, 0);
        end

        // Enable dropped mid-frame: frame completes, then silence.
        push_word({4'h0, 12'($urandom_range(1, 4095))});
        s = s + SP;
        run_frame("drop_en", s, 30);
        falls0 = cs_fall_cnt;
        sfalls0 = sclk_fall_cnt;
        repeat (300) @(negedge clk);
        chk("drop_en_cs_falls", cs_fall_cnt - falls0, 0);
        chk("drop_en_sclk_falls", sclk_fall_cnt - sfalls0, 0);
        chk("drop_en_cs_n_high", 32'(adc_cs_n), 1);

        // Reset pulse mid-shift discards the partial frame.
        adc_word = FB'($urandom_range(0, 16'hFFFF));
        enable = 1'b1;
        s = cyc + 1;
        while (cyc < s + 19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs_n", 32'(adc_cs_n), 1);
        chk("mid_rst_sclk", 32'(adc_sclk), 1);
        chk("mid_rst_data", 32'(adc_data), 0);
        chk("mid_rst_valid", 32'(adc_data_valid), 0);
        reset = 1'b1;
        push_word({4'h0, 12'($urandom_range(0, 4095))});
        s = cyc + 1;
        run_frame("after_rst", s, 0);

        // Wind down.
        enable = 1'b0;
        repeat (SP) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
